// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - ID/EX/M/WB sequencing: multiply residency, flush, load-use and interlock bubbles.
// Optional macro PIPE_CTRL_FWD_EN: forwarding present, only load-use interlocks.
module pipe_ctrl #(
   parameter int MUL_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] inst_if,
   input  logic        branch_taken,
   output logic [15:0] inst_id,
   output logic [15:0] inst_ex,
   output logic [15:0] inst_m,
   output logic [15:0] inst_wb,
   output logic        pc_en,
   output logic        flush,
   output logic        mul_busy
);

   typedef enum logic {RUN, MUL} state_t;

   localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 2);

   state_t     state;
   logic [3:0] cnt;
   logic       mul_stall;
   logic       take_branch;
   logic       hazard;

   function automatic logic is_writer(input logic [15:0] i);
      return (i[15:12] == 4'hF) || (i[15:12] == 4'h8);
   endfunction

   function automatic logic reads_reg(input logic [15:0] i, input logic [3:0] r);
      logic res;
      res = 1'b0;
      case (i[15:12])
         4'hF, 4'hB: res = (i[11:8] == r) || (i[7:4] == r);
         4'h8:       res = (i[7:4] == r);
         4'h4, 4'h5: res = (i[11:8] == r);
         default:    res = 1'b0;
      endcase
      return res;
   endfunction

   function automatic logic dep(input logic [15:0] prod, input logic [15:0] cons);
      return is_writer(prod) && reads_reg(cons, prod[11:8]);
   endfunction

   always_comb begin
      mul_stall   = ((state == RUN) && (inst_ex[15:12] == 4'hF) && (inst_ex[3:0] == 4'h4))
                 || ((state == MUL) && (cnt != 4'd0));
      take_branch = ((inst_ex[15:12] == 4'h4) || (inst_ex[15:12] == 4'h5)) && branch_taken;
`ifdef PIPE_CTRL_FWD_EN
      hazard      = (inst_ex[15:12] == 4'h8) && reads_reg(inst_id, inst_ex[11:8]);
`else
      hazard      = dep(inst_ex, inst_id) || dep(inst_m, inst_id) || dep(inst_wb, inst_id);
`endif
   end

   assign flush    = !rst && !mul_stall && take_branch;
   assign pc_en    = !rst && !mul_stall && (take_branch || !hazard);
   assign mul_busy = (state == MUL);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inst_id <= 16'h0000;
         inst_ex <= 16'h0000;
         inst_m  <= 16'h0000;
         inst_wb <= 16'h0000;
         state   <= RUN;
         cnt     <= 4'd0;
      end else if (mul_stall) begin
         // multiply parks in EX; M drains and receives bubbles
         inst_wb <= inst_m;
         inst_m  <= 16'h0000;
         if (state == RUN) begin
            state <= MUL;
            cnt   <= MUL_LOAD;
         end else begin
            cnt   <= cnt - 4'd1;
         end
      end else begin
         state   <= RUN;
         inst_wb <= inst_m;
         inst_m  <= inst_ex;
         if (take_branch) begin
            inst_ex <= 16'h0000;
            inst_id <= 16'h0000;
         end else if (hazard) begin
            inst_ex <= 16'h0000;
         end else begin
            inst_ex <= inst_id;
            inst_id <= inst_if;
         end
      end
   end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the 16-bit core. It owns the ID/EX/M/WB instruction registers that feed the forwarding unit and decides every cycle whether the pipeline advances, stalls or flushes. It handles load-use interlocks, multi-cycle multiply residency in EX, and taken-branch flushes. It sits between the fetch stage and the decode/forward/ALU stages.

## Interface
Parameters:
- MUL_CYCLES, 4: total cycles a multiply occupies EX; legal range 2..16.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- inst_if  in  16  instruction fetched this cycle
- branch_taken  in  1  branch in EX resolved taken; ignored unless inst_ex is a branch
- inst_id  out  16  registered decode-stage instruction
- inst_ex  out  16  registered execute-stage instruction
- inst_m  out  16  registered memory-stage instruction
- inst_wb  out  16  registered writeback-stage instruction
- pc_en  out  1  PC/fetch advance enable (combinational)
- flush  out  1  taken-branch flush indicator (combinational)
- mul_busy  out  1  high while state is MUL

## Operation
- Instruction fields: op=[15:12], ra=[11:8], rb=[7:4], fn=[3:0]. All 16 registers are real registers; none is hardwired to zero.
- Opcode classes:
  - 4'hF: ALU op; writes ra; reads ra and rb. fn=4'h4 is multiply.
  - 4'h8: load; writes ra; reads rb.
  - 4'hB: store; reads ra and rb.
  - 4'h4 and 4'h5: branch; reads ra.
  - 4'h0: nop. 16'h0000 is the bubble.
  - Any other opcode reads and writes nothing.
- States: RUN and MUL, plus a 4-bit down-counter cnt.
- Per-cycle action, in priority order:
  1. Multiply stall.
     - In RUN with a multiply in EX: stall and enter MUL with cnt=MUL_CYCLES-2.
     - In MUL with cnt!=0: stall and decrement cnt.
     - In MUL with cnt==0: advance normally and return to RUN.
  2. Flush: applies when inst_ex is a branch and branch_taken=1.
     - inst_m<=inst_ex; inst_ex<=0; inst_id<=0. inst_if is discarded. flush=1, pc_en=1.
  3. Load-use: applies when inst_ex is a load and inst_id reads inst_ex[11:8].
     - inst_m<=inst_ex; inst_ex<=0; inst_id holds; pc_en=0.
  4. Advance: wb<=m, m<=ex, ex<=id, id<=inst_if; pc_en=1.
- Stall (multiply): id and ex hold; m<=0; wb<=m; pc_en=0.
- A new multiply arriving in EX directly after a completed multiply re-triggers the stall (state is RUN again).
- A branch held in ID during a multiply stall is not evaluated until it reaches EX.

## Timing
- Reset (asynchronous): all inst_* = 16'h0000, state=RUN, cnt=0, mul_busy=0. While rst=1: pc_en=0, flush=0.
- pc_en and flush are combinational from the current registers and branch_taken. All other outputs are registered.
- Fetch-to-EX latency: 2 cycles when no stalls occur.
- Load-use costs exactly 1 bubble.
- A multiply holds EX for exactly MUL_CYCLES cycles; pc_en=0 for MUL_CYCLES-1 of them.
- A taken branch costs 2 bubbles (ID and IF squashed).
- Reset asserted mid-MUL aborts the multiply. After release the controller is in RUN with an empty pipeline.

## Configuration
- PIPE_CTRL_FWD_EN defined: the forwarding unit resolves EX/M/WB dependencies. Only the load-use interlock stalls.
- PIPE_CTRL_FWD_EN undefined: full interlock. Insert a load-use-style bubble (id holds, ex<=0, pc_en=0) whenever inst_id reads ra of a writing instruction in inst_ex, inst_m or inst_wb. Multiply and flush priorities are unchanged.

## Test plan
- Reset then inst_if=F010,F100,F7A0 with no hazards (FWD_EN) -> inst_ex shows F010 two cycles after fetch; pc_en constantly 1; no bubbles.
- Load-use: inst_ex=8120 (load $1), inst_id=F310 (reads $1) -> one cycle with pc_en=0 and inst_ex=0000, inst_id=F310 held; next cycle inst_ex=F310.
- Multiply with MUL_CYCLES=4: F234 enters EX -> inst_ex=F234 for 4 cycles; mul_busy=1 for 3 cycles; pc_en=0 for 3 cycles; inst_m=0000 until F234 moves to M.
- Taken branch: inst_ex=4500, branch_taken=1 -> flush=1; next cycle inst_ex=0000, inst_id=0000, inst_m=4500.
- Without PIPE_CTRL_FWD_EN: inst_m=F590 (writes $5), inst_id=F570 -> bubble inserted until F590 leaves WB (2 stall cycles). With FWD_EN: 0 stalls.
- Reset asserted in the second MUL cycle -> all inst_* = 0000, mul_busy=0 immediately; the first fetch after release advances normally.
